// File: rtl/nn_fixed_pkg.sv
// nn_fixed_pkg: shared Q8.8 widths, params_out word map and loader states
package nn_fixed_pkg;
    localparam int WIDTH      = 16;
    localparam int FRAC       = 8;
    localparam int NUM_PARAMS = 12;
    localparam logic [3:0] CNT_LAST = 4'(NUM_PARAMS);
    localparam int IDX_COEFF1_0 = 0;
    localparam int IDX_COEFF1_1 = 1;
    localparam int IDX_COEFF1_2 = 2;
    localparam int IDX_COEFF1_3 = 3;
    localparam int IDX_COEFF2_0 = 4;
    localparam int IDX_COEFF2_1 = 5;
    localparam int IDX_COEFF2_2 = 6;
    localparam int IDX_COEFF2_3 = 7;
    localparam int IDX_BIAS1_0  = 8;
    localparam int IDX_BIAS1_1  = 9;
    localparam int IDX_BIAS2_0  = 10;
    localparam int IDX_BIAS2_1  = 11;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_COMMIT} loader_state_t;
endpackage

// File: rtl/nn_param_sum.sv
// nn_param_sum: modulo-2^WIDTH running sum with clear/enable and checksum compare
module nn_param_sum
    import nn_fixed_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_cmp,
    output logic             o_match
);
    logic [WIDTH-1:0] r_sum;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r_sum <= '0;
        else if (i_clr)
            r_sum <= '0;
        else if (i_en)
            r_sum <= r_sum + i_data;

    assign o_match = (r_sum == i_cmp);
endmodule

// File: rtl/nn_param_loader.sv
// nn_param_loader: framed, checksum-verified loader that commits 12 Q8.8 words atomically
module nn_param_loader
    import nn_fixed_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [NUM_PARAMS*WIDTH-1:0] params_out,
    output logic                        params_valid,
    output logic                        loading,
    output logic                        done,
    output logic                        err
);
    loader_state_t                         r_state;
    logic [3:0]                            r_cnt;
    logic [NUM_PARAMS-1:0][WIDTH-1:0]      r_shadow;
    logic [NUM_PARAMS-1:0][WIDTH-1:0]      r_params;
    logic                                  r_ready, r_valid, r_loading, r_done, r_err;
    logic                                  w_beat, w_clr, w_en, w_match;

    // start outranks any beat presented in the same cycle
    assign w_beat = (r_state == ST_LOAD) && in_valid && !start;
    assign w_clr  = start && (r_state != ST_COMMIT);
    assign w_en   = w_beat && (r_cnt != CNT_LAST);

    nn_param_sum u_sum (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .i_data  (in_data),
        .i_cmp   (in_data),
        .o_match (w_match)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_shadow  <= '0;
            r_params  <= '0;
            r_ready   <= 1'b0;
            r_valid   <= 1'b0;
            r_loading <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE:
                    if (start) begin
                        r_state   <= ST_LOAD;
                        r_cnt     <= '0;
                        r_ready   <= 1'b1;
                        r_loading <= 1'b1;
                    end
                ST_LOAD:
                    if (start)
                        r_cnt <= '0;
                    else if (w_beat) begin
                        if (r_cnt == CNT_LAST) begin
                            r_ready   <= 1'b0;
                            r_loading <= 1'b0;
                            r_err     <= !w_match;
                            r_state   <= w_match ? ST_COMMIT : ST_IDLE;
                        end else begin
                            r_shadow[r_cnt] <= in_data;
                            r_cnt           <= r_cnt + 4'd1;
                        end
                    end
                default: begin
                    r_params <= r_shadow;
                    r_valid  <= 1'b1;
                    r_done   <= 1'b1;
                    r_state  <= ST_IDLE;
                end
            endcase
        end

    assign in_ready     = r_ready;
    assign params_out   = r_params;
    assign params_valid = r_valid;
    assign loading      = r_loading;
    assign done         = r_done;
    assign err          = r_err;
endmodule
